// File: rtl/axi_mem_pkg.sv
// Shared types and sizing helpers for the block-RAM AXI responder.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_RESP = 2'd2,
        ST_RD_DATA = 2'd3
    } state_e;

    localparam int DEF_MEM_AW     = 10;
    localparam int DEF_DATA_LEVEL = 2;
    localparam int MEM_DEPTH      = 1 << DEF_MEM_AW;
    localparam int DQ_SHIFT       = $clog2(DEF_DATA_LEVEL);

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int dq_shift(input int level);
        return $clog2(level);
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Single-port synchronous RAM; a read returns data on the cycle after en.
module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = DEF_MEM_AW
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [MEM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = depth_of(MEM_AW);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// Block-RAM backed AXI burst responder standing in for ddr2_ctrl.
// One FSM serves either a write burst (AW/W/B) or a read burst (AR/R) at a time.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_LEVEL = DEF_DATA_LEVEL,
    parameter int MEM_AW     = DEF_MEM_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic                  axi_wlast,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic                  axi_rlast,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic                  proto_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds with its payload until then, and ready here may
    // depend combinationally on valid (AW/AR arbitration).

    localparam int SHIFT = dq_shift(DATA_LEVEL);

    state_e                state, state_nxt;
    logic                  prio_wr;
    logic [MEM_AW-1:0]     idx;
    logic [8:0]            beats_left;
    logic                  rd_inflight, rd_inflight_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  grant_wr, grant_rd;
    logic                  wr_beat, rd_issue, rd_issue_last, rd_pop;
    logic [1:0]            occ_after;
    logic                  ram_en, ram_we;
    logic [MEM_AW-1:0]     ram_addr, ar_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign ar_idx     = MEM_AW'(axi_araddr >> SHIFT);
    assign axi_rvalid = (fifo_cnt != 2'd0) && !rst;
    assign axi_rdata  = fifo_data[rd_ptr];
    assign axi_rlast  = axi_rvalid && fifo_last[rd_ptr];
    assign rd_pop     = axi_rvalid && axi_rready;
    assign wr_beat    = axi_wready && axi_wvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        axi_awready   = 1'b0;
        axi_arready   = 1'b0;
        axi_wready    = 1'b0;
        axi_bvalid    = 1'b0;
        rd_issue      = 1'b0;
        rd_issue_last = 1'b0;
        grant_wr      = axi_awvalid && (!axi_arvalid || prio_wr);
        grant_rd      = axi_arvalid && (!axi_awvalid || !prio_wr);
        // The pop this cycle frees a slot, which is what keeps reads back-to-back.
        occ_after     = fifo_cnt - {1'b0, rd_pop} + {1'b0, rd_inflight};
        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    axi_awready = grant_wr;
                    axi_arready = grant_rd;
                    if (grant_wr) begin
                        state_nxt = ST_WR_DATA;
                    end else if (grant_rd) begin
                        state_nxt     = ST_RD_DATA;
                        rd_issue      = 1'b1;
                        rd_issue_last = (axi_arlen == 8'd0);
                    end
                end
                ST_WR_DATA: begin
                    axi_wready = 1'b1;
                    if (axi_wvalid && beats_left == 9'd1) begin
                        state_nxt = ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    axi_bvalid = 1'b1;
                    if (axi_bready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RD_DATA: begin
                    rd_issue      = (beats_left != 9'd0) && (occ_after < 2'd2);
                    rd_issue_last = (beats_left == 9'd1);
                    if (rd_pop && fifo_last[rd_ptr]) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // The first read of a burst is issued straight from araddr while granting.
    assign ram_we   = wr_beat;
    assign ram_en   = wr_beat || rd_issue;
    assign ram_addr = (state == ST_IDLE) ? ar_idx : idx;

    axi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_AW     (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (axi_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_wr          <= 1'b1;
            idx              <= '0;
            beats_left       <= '0;
            proto_err        <= 1'b0;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
            fifo_data[0]     <= '0;
            fifo_data[1]     <= '0;
            fifo_last        <= '0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            fifo_cnt         <= '0;
        end else begin
            if (axi_awready) begin
                prio_wr    <= ~prio_wr;
                idx        <= MEM_AW'(axi_awaddr >> SHIFT);
                beats_left <= {1'b0, axi_awlen} + 9'd1;
            end else if (axi_arready) begin
                prio_wr    <= ~prio_wr;
                idx        <= ar_idx + MEM_AW'(1);
                beats_left <= {1'b0, axi_arlen};
            end else if (wr_beat || rd_issue) begin
                idx        <= idx + MEM_AW'(1);
                beats_left <= beats_left - 9'd1;
            end

            // The count alone ends the burst; wlast is only cross-checked.
            if (wr_beat && (axi_wlast != (beats_left == 9'd1))) begin
                proto_err <= 1'b1;
            end

            rd_inflight      <= rd_issue;
            rd_inflight_last <= rd_issue && rd_issue_last;

            if (rd_inflight) begin
                fifo_data[wr_ptr] <= ram_rdata;
                fifo_last[wr_ptr] <= rd_inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (rd_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, rd_pop};
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: directed bursts plus random traffic, checked against
// a word-array memory model and an expected-data queue.
module tb_axi_mem_slave;

    localparam int ADDR_WIDTH = 26;
    localparam int DATA_WIDTH = 32;
    localparam int DATA_LEVEL = 2;
    localparam int MEM_AW     = 4;
    localparam int DEPTH      = 1 << MEM_AW;

    logic                  clk;
    logic                  rst;
    logic                  axi_awvalid, axi_awready;
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [7:0]            axi_awlen;
    logic                  axi_wvalid, axi_wready, axi_wlast;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic                  axi_bvalid, axi_bready;
    logic                  axi_arvalid, axi_arready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]            axi_arlen;
    logic                  axi_rvalid, axi_rready, axi_rlast;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic                  proto_err;

    int                    total = 0;
    int                    bad   = 0;
    logic [DATA_WIDTH-1:0] model_mem [DEPTH];
    logic [DATA_WIDTH-1:0] exp_q [$];
    logic                  exp_perr;
    logic [ADDR_WIDTH-1:0] a;
    int                    n;

    axi_mem_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_LEVEL (DATA_LEVEL),
        .MEM_AW     (MEM_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wlast   (axi_wlast),
        .axi_wdata   (axi_wdata),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rlast   (axi_rlast),
        .axi_rdata   (axi_rdata),
        .proto_err   (proto_err)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int idx_of(input logic [ADDR_WIDTH-1:0] addr);
        return (int'(addr) / DATA_LEVEL) % DEPTH;
    endfunction

    // Drives W beats from a negedge in WR_DATA, then the B response.
    task automatic write_beats(input int i0, input int len, input int wlast_beat,
                               input logic [31:0] base, input bit rnd);
        logic [31:0] d;
        int k;
        for (int b = 0; b <= len; b++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                axi_wvalid = 1'b0;
                @(negedge clk);
            end
            d = rnd ? $urandom : base + 32'(b);
            axi_wvalid = 1'b1;
            axi_wdata  = d;
            axi_wlast  = (b == wlast_beat);
            #1;
            check("wready", axi_wready, 1);
            model_mem[(i0 + b) % DEPTH] = d;
            @(negedge clk);
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        if (wlast_beat != len) exp_perr = 1'b1;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) begin
            #1;
            check("bvalid_hold", axi_bvalid, 1);
            @(negedge clk);
        end
        axi_bready = 1'b1;
        #1;
        check("bvalid", axi_bvalid, 1);
        check("wready_off", axi_wready, 0);
        @(negedge clk);
        axi_bready = 1'b0;
        #1;
        check("b_once", axi_bvalid, 0);
        check("proto_err", proto_err, exp_perr);
    endtask

    // Collects R beats from the first negedge after the AR handshake.
    // mode 0: rready held high, 1: toggling, 2: random.
    task automatic read_beats(input int i0, input int len, input int mode);
        int cyc, got, first, last_cyc;
        bit held_v, held_l;
        logic [31:0] held_d, e;
        exp_q.delete();
        for (int b = 0; b <= len; b++) exp_q.push_back(model_mem[(i0 + b) % DEPTH]);
        cyc = 1; got = 0; first = 0; last_cyc = 0; held_v = 0; held_l = 0; held_d = '0;
        while (got <= len && cyc < 1200) begin
            axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            #1;
            if (held_v) begin
                check("r_stable_data", axi_rdata, held_d);
                check("r_stable_ctl", {axi_rvalid, axi_rlast}, {1'b1, held_l});
            end
            if (axi_rvalid && first == 0) first = cyc;
            if (axi_rvalid && axi_rready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("r_data", axi_rdata, e);
                check("r_last", axi_rlast, (got == len));
                got++;
                last_cyc = cyc;
            end
            held_v = axi_rvalid && !axi_rready;
            held_l = axi_rlast;
            held_d = axi_rdata;
            @(negedge clk);
            cyc++;
        end
        check("r_count", got, len + 1);
        check("r_latency", first, 2);
        if (mode == 0) check("r_no_gap", last_cyc - first, len);
        axi_rready = 1'b0;
        #1;
        check("r_done", axi_rvalid, 0);
    endtask

    task automatic write_burst(input logic [ADDR_WIDTH-1:0] addr, input int len, input int wlast_beat,
                               input logic [31:0] base, input bit rnd);
        int w;
        @(negedge clk);
        axi_awvalid = 1'b1;
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        w = 0;
        #1;
        while (!axi_awready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("awready", axi_awready, 1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        write_beats(idx_of(addr), len, wlast_beat, base, rnd);
    endtask

    task automatic read_burst(input logic [ADDR_WIDTH-1:0] addr, input int len, input int mode);
        int w;
        @(negedge clk);
        axi_arvalid = 1'b1;
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        w = 0;
        #1;
        while (!axi_arready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("arready", axi_arready, 1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        read_beats(idx_of(addr), len, mode);
    endtask

    // Simultaneous AW/AR: write wins after reset, then read, then write again.
    task automatic arb_pair(input logic [ADDR_WIDTH-1:0] addr, input int len, input logic [31:0] base);
        int i0;
        i0 = idx_of(addr);
        @(negedge clk);
        axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = 8'(len);
        axi_arvalid = 1'b1; axi_araddr = addr; axi_arlen = 8'(len);
        #1;
        check("arb1_aw", axi_awready, 1);
        check("arb1_ar", axi_arready, 0);
        @(negedge clk);
        axi_awvalid = 1'b0;
        write_beats(i0, len, len, base, 1'b0);
        axi_awvalid = 1'b1;
        #1;
        check("arb2_ar", axi_arready, 1);
        check("arb2_aw", axi_awready, 0);
        @(negedge clk);
        axi_arvalid = 1'b0;
        read_beats(i0, len, 0);
        check("arb3_aw", axi_awready, 1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        write_beats(i0, len, len, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        axi_awvalid = 1'b1; axi_awaddr = '0; axi_awlen = '0;
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_wdata = '0;
        axi_bready = 1'b0;
        axi_arvalid = 1'b1; axi_araddr = '0; axi_arlen = '0;
        axi_rready = 1'b0;
        exp_perr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", axi_awready, 0);
        check("rst_arready", axi_arready, 0);
        check("rst_wready", axi_wready, 0);
        check("rst_bvalid", axi_bvalid, 0);
        check("rst_rvalid", axi_rvalid, 0);
        check("rst_rlast", axi_rlast, 0);
        check("rst_rdata", axi_rdata, 0);
        check("rst_proto_err", proto_err, 0);
        @(negedge clk);
        rst = 1'b0;
        axi_awvalid = 1'b0;
        axi_arvalid = 1'b0;

        // write 1..4 at 0, read back, then alternation
        arb_pair('0, 3, 32'd1);

        // fill the whole model so any later read has known data
        write_burst('0, DEPTH - 1, DEPTH - 1, '0, 1'b1);

        a = ADDR_WIDTH'($urandom);
        read_burst(a, 7, 1);
        read_burst(a, 7, 0);

        // early wlast on beat 2 of 4
        a = ADDR_WIDTH'($urandom);
        write_burst(a, 3, 1, '0, 1'b1);
        read_burst(a, 3, 0);

        // index wrap: addr 30 -> index 15, then 0
        write_burst(ADDR_WIDTH'(30), 1, 1, 32'hA, 1'b0);
        read_burst(ADDR_WIDTH'(30), 1, 0);
        read_burst('0, 0, 0);

        // maximum-length bursts
        write_burst(ADDR_WIDTH'($urandom), 255, 255, '0, 1'b1);
        read_burst(ADDR_WIDTH'($urandom), 255, 2);

        for (int it = 0; it < 16; it++) begin
            a = ADDR_WIDTH'($urandom);
            n = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) write_burst(a, n, n, '0, 1'b1);
            else read_burst(a, n, $urandom_range(0, 2));
        end

        // reset during beat 2 of a 4-beat read
        @(negedge clk);
        axi_arvalid = 1'b1; axi_araddr = ADDR_WIDTH'(4); axi_arlen = 8'd3;
        #1;
        check("mid_ar", axi_arready, 1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        @(negedge clk);
        #1;
        check("mid_beat1", axi_rvalid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        axi_rready = 1'b0;
        exp_perr = 1'b0;
        #1;
        check("mid_rvalid", axi_rvalid, 0);
        check("mid_rlast", axi_rlast, 0);
        check("mid_rdata", axi_rdata, 0);
        check("mid_bvalid", axi_bvalid, 0);
        check("mid_wready", axi_wready, 0);
        check("mid_proto_err", proto_err, 0);
        axi_arvalid = 1'b1;
        #1;
        check("mid_arready", axi_arready, 1);
        axi_arvalid = 1'b0;
        arb_pair(ADDR_WIDTH'(12), 2, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
